// File: rtl/se_sched_pkg.sv
// se_sched_pkg: shared encodings and default widths for the SE request
// scheduler slice.
package se_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam int DEF_INST_W = 8;
  localparam int DEF_DATA_W = 128;
  localparam int CNTR_W     = 8;

endpackage

// File: rtl/se_rr_arbiter.sv
// se_rr_arbiter: combinational round-robin pick, searching cyclically
// upward from the pointer.
module se_rr_arbiter
  import se_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[IW'(j)]) begin
        any_o = 1'b1;
        idx_o = IW'(j);
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/se_req_scheduler.sv
// se_req_scheduler: shares one rolled SE among NUM_REQ requesters with
// round-robin grants, per-op latency reporting and a WAIT watchdog.
module se_req_scheduler
  import se_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int LAT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*INST_W-1:0] req_inst,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*DATA_W-1:0] req_cond,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_err,
  output logic [INST_W-1:0]         se_in_inst,
  output logic [DATA_W-1:0]         se_in_op1,
  output logic [DATA_W-1:0]         se_in_op2,
  output logic [DATA_W-1:0]         se_in_cond,
  output logic                      se_in_valid,
  input  logic                      se_in_ready,
  input  logic [DATA_W-1:0]         se_out_result,
  input  logic                      se_out_valid,
  output logic                      se_out_ready,
  input  logic [CNTR_W-1:0]         se_out_cntr,
  output logic [LAT_W-1:0]          last_lat,
  output logic [CNTR_W-1:0]         last_cntr,
  output logic                      busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LAT_W-1:0] TMO_LAST = LAT_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] TMO_VAL  = LAT_W'(TIMEOUT);

  state_e              state_q;
  logic [IW-1:0]       ptr_q, owner_q;
  logic [INST_W-1:0]   inst_q;
  logic [DATA_W-1:0]   op1_q, op2_q, cond_q, res_q;
  logic [LAT_W-1:0]    lat_q, last_lat_q;
  logic [CNTR_W-1:0]   last_cntr_q;
  logic                err_q, drain_q;

  logic [INST_W-1:0]   inst_a [NUM_REQ];
  logic [DATA_W-1:0]   op1_a  [NUM_REQ];
  logic [DATA_W-1:0]   op2_a  [NUM_REQ];
  logic [DATA_W-1:0]   cond_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign inst_a[g] = req_inst[g*INST_W +: INST_W];
    assign op1_a[g]  = req_op1[g*DATA_W +: DATA_W];
    assign op2_a[g]  = req_op2[g*DATA_W +: DATA_W];
    assign cond_a[g] = req_cond[g*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] gnt, own_oh;
  logic [IW-1:0]      gidx, ptr_nxt;
  logic               gany;

  se_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign ptr_nxt = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    own_oh = '0;
    own_oh[owner_q] = 1'b1;
  end

  // Reset must also suppress the combinational accept.
  assign req_ready    = (state_q == S_IDLE && !reset) ? gnt : '0;
  assign rsp_valid    = (state_q == S_RESP) ? own_oh : '0;
  assign se_in_valid  = (state_q == S_ISSUE);
  assign se_out_ready = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign busy         = (state_q != S_IDLE);
  assign se_in_inst   = inst_q;
  assign se_in_op1    = op1_q;
  assign se_in_op2    = op2_q;
  assign se_in_cond   = cond_q;
  assign rsp_result   = res_q;
  assign rsp_err      = err_q;
  assign last_lat     = last_lat_q;
  assign last_cntr    = last_cntr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      inst_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      cond_q      <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      drain_q     <= 1'b0;
      lat_q       <= '0;
      last_lat_q  <= '0;
      last_cntr_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (gany) begin
            inst_q  <= inst_a[gidx];
            op1_q   <= op1_a[gidx];
            op2_q   <= op2_a[gidx];
            cond_q  <= cond_a[gidx];
            owner_q <= gidx;
            ptr_q   <= ptr_nxt;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (se_in_ready) begin
            lat_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_q != '1) lat_q <= lat_q + 1'b1;
          // A result arriving on the watchdog cycle takes priority.
          if (se_out_valid) begin
            res_q       <= se_out_result;
            err_q       <= 1'b0;
            last_lat_q  <= lat_q;
            last_cntr_q <= se_out_cntr;
            state_q     <= S_RESP;
          end else if (lat_q == TMO_LAST) begin
            res_q      <= '0;
            err_q      <= 1'b1;
            last_lat_q <= TMO_VAL;
            drain_q    <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[owner_q]) begin
            state_q <= drain_q ? S_DRAIN : S_IDLE;
          end
        end
        S_DRAIN: begin
          if (se_out_valid) begin
            drain_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/se_req_scheduler.md
Name: se_req_scheduler

Overview:
- Shares one rolled SE datapath instance among NUM_REQ requester ports.
- Round-robin arbitration; exactly one SE operation in flight at a time.
- Routes each result back to its owning requester.
- Reports issue-to-result latency and SE cycle count per operation so timing-leak monitors can compare runs.
- A watchdog bounds how long a requester can wait on a hung SE.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- DATA_W, 128, operand/result width.
- INST_W, 8, instruction width.
- LAT_W, 16, latency counter width.
- TIMEOUT, 1024, WAIT cycles before the error response; must be < 2^LAT_W.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_inst  in  NUM_REQ*INST_W  packed instructions; requester i at slice i.
- req_op1 / req_op2 / req_cond  in  NUM_REQ*DATA_W each  packed operands.
- rsp_valid  out  NUM_REQ  response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  DATA_W  shared result bus; meaningful only while a rsp_valid bit is high.
- rsp_err  out  1  response is a timeout; rsp_result = 0.
- se_in_inst  out  INST_W  to SE.
- se_in_op1 / se_in_op2 / se_in_cond  out  DATA_W  to SE.
- se_in_valid  out  1  to SE.
- se_in_ready  in  1  from SE.
- se_out_result  in  DATA_W  from SE.
- se_out_valid  in  1  from SE.
- se_out_ready  out  1  to SE.
- se_out_cntr  in  8  SE internal cycle counter.
- last_lat  out  LAT_W  WAIT cycles of the most recent completed op.
- last_cntr  out  8  se_out_cntr sampled with the most recent result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset, synchronous and active-high, wins over all other activity, including mid-operation:
  - state = IDLE; rr pointer = 0; all valid/ready outputs = 0.
  - Operand registers, rsp_result, last_lat and last_cntr = 0; rsp_err = 0.
  - Any in-flight SE op is abandoned; the SE is reset on the same reset.
- IDLE:
  - grant = first index with req_valid set, searching cyclically from the rr pointer.
  - req_ready[grant] = 1 combinationally; all other req_ready bits = 0.
  - On grant: register inst/op1/op2/cond and owner = grant; pointer = (grant+1) mod NUM_REQ; go to ISSUE.
  - No req_valid: stay in IDLE; pointer unchanged.
- ISSUE:
  - se_in_valid = 1; registered operands driven stable.
  - On se_in_ready: lat counter = 0; go to WAIT.
  - No timeout applies in ISSUE.
- WAIT:
  - se_out_ready = 1; lat counter increments each cycle, saturating at all-ones.
  - On se_out_valid: capture rsp_result, last_lat = counter, last_cntr = se_out_cntr; rsp_err = 0; go to RESP.
  - If counter == TIMEOUT-1 with no se_out_valid that cycle: rsp_result = 0, rsp_err = 1, last_lat = TIMEOUT; go to RESP and set the drain flag.
  - se_out_valid in the same cycle as the timeout: the result wins.
- RESP:
  - rsp_valid[owner] = 1; result and err held stable.
  - On rsp_ready[owner]: go to DRAIN if the drain flag is set, else IDLE.
  - rsp_ready on non-owner bits is ignored.
- DRAIN:
  - se_out_ready = 1; on se_out_valid discard the result, clear the drain flag, go to IDLE.
  - No req_ready is given in DRAIN.
- req_ready is never high outside IDLE; at most one operation is ever outstanding.
- Fairness: a continuously requesting port is granted within NUM_REQ grants.
- Latency:
  - Accept at cycle t gives se_in_valid at t+1.
  - SE handshake on se_out_valid at cycle u gives rsp_valid at u+1.
  - RESP handshake at cycle v gives IDLE (new grant possible) at v+1.
- A requester that drops req_valid before being granted loses nothing; no pending state is kept.

Decomposition:
- Package se_sched_pkg:
  - State encoding IDLE=0, ISSUE=1, WAIT=2, RESP=3, DRAIN=4 (3 bits).
  - Default width constants (INST_W, DATA_W, CNTR_W=8).
- Sub-module se_rr_arbiter:
  - Combinational round-robin pick.
  - Inputs: req vector, pointer. Outputs: one-hot grant, grant index, any.
- FSM, operand/result registers and watchdog live in se_req_scheduler.

Test Plan:
- Single request: req0 with op1=5, op2=3; SE model returns 0x8 after 4 WAIT cycles. Expect rsp_valid=01, rsp_result=0x8, last_lat=4, rsp_err=0, busy back to 0 one cycle after rsp_ready.
- Contention, NUM_REQ=2, both req_valid held for 4 operations after reset: grant order 0,1,0,1; each rsp_valid goes only to the requester that was granted.
- Backpressure: se_in_ready low 3 cycles in ISSUE, then rsp_ready low 5 cycles in RESP. Expect operands, result and rsp_valid stable throughout, and no new req_ready during either stall.
- Timeout, TIMEOUT=16, SE never responds: rsp_err=1, rsp_result=0, last_lat=16, rsp_valid in the cycle after the 16th WAIT cycle. After the handshake the block stays in DRAIN until a late se_out_valid, then returns to IDLE.
- Timeout tie: se_out_valid arrives on WAIT cycle 15 with TIMEOUT=16. Expect the normal result, rsp_err=0, and no DRAIN.
- Reset mid-operation: assert reset in WAIT. Next cycle all outputs are 0 and state is IDLE; the first post-reset grant goes to requester 0.
